pwm_ramp: RTL and testbench
===========================

# pwm_ramp

Soft-start/soft-stop duty sequencer sitting directly upstream of the PWM generator. It drives that generator's `ftw`, `duty` and `load` inputs. The PWM generator runs a period of `ftw+1` clocks and is high while its counter is below `duty`. On a start command this block ramps `duty` in fixed steps from its current value toward a programmed target, and pulses `load` on every update. On a stop command it ramps back down to 0 and goes idle.

## Interface
- `U_DLY`, 1: simulation delay on registered assignments.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse; captures `cfg_*` and begins a ramp toward `cfg_target`.
- `stop` in 1: one-cycle pulse; begins a ramp toward 0, then goes idle.
- `cfg_ftw` in 32: PWM period minus one.
- `cfg_target` in 32: target duty in clocks.
- `cfg_step` in 32: duty change per step; 0 means jump straight to the target.
- `cfg_interval` in 32: ticks between steps minus one.
- `ftw` out 32: period word to the PWM generator.
- `duty` out 32: current duty to the PWM generator.
- `load` out 1: one-cycle pulse whenever `ftw` or `duty` changes.
- `busy` out 1: high in RAMP and HOLD.
- `done` out 1: one-cycle pulse when a ramp reaches its target.

## Operation
- States: IDLE, RAMP, HOLD. Reset state is IDLE.
- Shadow registers `ftw_s`, `tgt_s`, `step_s`, `int_s` are loaded from `cfg_*` on `start`.
- Effective target `tgt_s`:
  - if `cfg_target > cfg_ftw`, `tgt_s = cfg_ftw+1`, computed in 33 bits and saturated at 0xFFFFFFFF;
  - otherwise `tgt_s = cfg_target`.
- `start` (in any state, with `stop` low):
  - capture the shadows and set `ftw <= cfg_ftw`;
  - `duty` keeps its current value, so a ramp may run up or down;
  - clear the interval counter and enter RAMP;
  - pulse `load` on the following cycle.
- `stop` (in RAMP or HOLD):
  - set `tgt_s = 0` and keep `step_s` and `int_s`;
  - clear the interval counter, set the stopping flag and enter RAMP.
- `stop` in IDLE is ignored. If `start` and `stop` arrive in the same cycle, `stop` wins.
- RAMP step rule:
  - the interval counter counts ticks from 0 to `int_s`;
  - on the tick where it equals `int_s` it wraps to 0 and `duty` steps;
  - stepping up: `duty = min(duty+step_s, tgt_s)`, sum computed in 33 bits;
  - stepping down: `duty = max(duty-step_s, tgt_s)`, with no underflow;
  - if `step_s == 0`, `duty = tgt_s`;
  - every step pulses `load`.
- When the new `duty` equals `tgt_s`, pulse `done` in the same cycle as that `load`. Then:
  - if the stopping flag is set, go to IDLE and clear the flag;
  - otherwise go to HOLD.
- Entering RAMP with `duty == tgt_s` still runs one interval, then issues `load` and `done` with no change.
- HOLD: outputs are static; only `start` or `stop` leave this state.
- Reset mid-operation: all state is cleared immediately. Outputs reset to `ftw=0`, `duty=0`, `load=0`, `busy=0`, `done=0`.

## Timing
- `start` sampled at cycle N: `ftw` updates and `load` pulses at N+1.
- Tick = one clock (see Configuration).
- First step occurs `int_s+1` ticks after RAMP entry. Subsequent steps follow every `int_s+1` ticks.
- Ramp length is `ceil(|duty-tgt_s|/step_s)` steps.
- `busy` rises at N+1 after `start`. It falls in the cycle after the final `done` of a stop ramp.
- `done` and `load` are registered outputs, one cycle wide.

## Configuration
- `PWM_RAMP_PERIOD_SYNC_EN` defined:
  - a free-running period counter counts 0 to `ftw_s` and restarts on every RAMP entry;
  - a tick is the wrap of this counter, so steps land only on PWM period boundaries and `cfg_interval` counts in PWM periods.
- `PWM_RAMP_PERIOD_SYNC_EN` undefined:
  - a tick is every clock;
  - the period counter is not built.

## Test plan
- Up-ramp: `cfg_ftw=99`, `target=50`, `step=10`, `interval=3`, start from reset → `duty` goes 10, 20, 30, 40, 50, one step every 4 clocks; `load` pulses 6 times in total (1 for `ftw` + 5 steps); `done` coincides with the last pulse; state HOLD, `busy=1`.
- Overshoot clamp: `target=45`, `step=20`, `interval=0` → `duty` goes 20, 40, 45; `done` at 45.
- Target above period: `cfg_ftw=9`, `target=200`, `step=0` → single jump to `duty=10`; `done` pulses.
- Stop from HOLD at `duty=50`, `step=20`, `interval=1` → `duty` goes 30, 10, 0, one step every 2 clocks; `done` at 0; IDLE; `busy` low the next cycle.
- Simultaneous `start`+`stop` in HOLD → stop behaviour only; shadows unchanged. `start` during RAMP → shadows recaptured, interval counter restarts, ramp continues from current `duty`. Assert `rst_n` low mid-ramp → all outputs 0 asynchronously.
- With `PWM_RAMP_PERIOD_SYNC_EN`: `cfg_ftw=4`, `interval=1`, `step=5`, `target=5` → single step, exactly 10 clocks after RAMP entry.

Source files
------------

// File: rtl/pwm_ramp.sv
// Soft-start/soft-stop duty sequencer driving a PWM generator's ftw/duty/load inputs.
// Optional macro PWM_RAMP_PERIOD_SYNC_EN: ramp steps land only on PWM period boundaries.
module pwm_ramp #(
    parameter int U_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] cfg_ftw,
    input  logic [31:0] cfg_target,
    input  logic [31:0] cfg_step,
    input  logic [31:0] cfg_interval,
    output logic [31:0] ftw,
    output logic [31:0] duty,
    output logic        load,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // U_DLY is kept for interface compatibility; registered updates here carry no delay.
    if (U_DLY < 0) begin : g_u_dly_negative
    end

    // A target beyond the period is clamped to a fully-on duty of period+1.
    function automatic logic [31:0] eff_target(input logic [31:0] tgt, input logic [31:0] per);
        logic [32:0] lim;
        lim = {1'b0, per} + 33'd1;
        if (tgt > per) begin
            eff_target = lim[32] ? 32'hFFFF_FFFF : lim[31:0];
        end else begin
            eff_target = tgt;
        end
    endfunction

    function automatic logic [31:0] next_duty(input logic [31:0] cur, input logic [31:0] tgt,
                                              input logic [31:0] stp);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, stp};
        if (stp == 32'd0) begin
            next_duty = tgt;
        end else if (cur < tgt) begin
            next_duty = (sum > {1'b0, tgt}) ? tgt : sum[31:0];
        end else if (cur > tgt) begin
            next_duty = ((cur - tgt) > stp) ? (cur - stp) : tgt;
        end else begin
            next_duty = tgt;
        end
    endfunction

    logic [1:0]  state_r;
    logic [31:0] ftw_r;
    logic [31:0] duty_r;
    logic [31:0] tgt_r;
    logic [31:0] step_r;
    logic [31:0] int_r;
    logic [31:0] cnt_r;
    logic        stopping_r;
    logic        load_r;
    logic        done_r;
    logic        busy_r;
    logic        tick_s;
    logic        do_stop_s;
    logic        do_start_s;
    logic [31:0] new_duty_s;

`ifdef PWM_RAMP_PERIOD_SYNC_EN
    logic [31:0] pcnt_r;

    // Free-running PWM period counter, realigned to every RAMP entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= 32'd0;
        end else if (do_stop_s || do_start_s || (pcnt_r == ftw_r)) begin
            pcnt_r <= 32'd0;
        end else begin
            pcnt_r <= pcnt_r + 32'd1;
        end
    end

    assign tick_s = (pcnt_r == ftw_r);
`else
    assign tick_s = 1'b1;
`endif

    // Command decode and next duty value; stop outranks start and is ignored while idle.
    always_comb begin
        do_stop_s  = stop && (state_r != ST_IDLE);
        do_start_s = start && !stop;
        new_duty_s = next_duty(duty_r, tgt_r, step_r);
    end

    // Sequencer state, shadow registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ftw_r      <= 32'd0;
            duty_r     <= 32'd0;
            tgt_r      <= 32'd0;
            step_r     <= 32'd0;
            int_r      <= 32'd0;
            cnt_r      <= 32'd0;
            stopping_r <= 1'b0;
            load_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            load_r <= 1'b0;
            done_r <= 1'b0;
            if (do_stop_s) begin
                tgt_r      <= 32'd0;
                cnt_r      <= 32'd0;
                stopping_r <= 1'b1;
                state_r    <= ST_RAMP;
                busy_r     <= 1'b1;
            end else if (do_start_s) begin
                ftw_r      <= cfg_ftw;
                tgt_r      <= eff_target(cfg_target, cfg_ftw);
                step_r     <= cfg_step;
                int_r      <= cfg_interval;
                cnt_r      <= 32'd0;
                stopping_r <= 1'b0;
                state_r    <= ST_RAMP;
                load_r     <= 1'b1;
                busy_r     <= 1'b1;
            end else if ((state_r == ST_RAMP) && tick_s) begin
                busy_r <= 1'b1;
                if (cnt_r == int_r) begin
                    cnt_r  <= 32'd0;
                    duty_r <= new_duty_s;
                    load_r <= 1'b1;
                    // busy stays high through the final done of a stop ramp, dropping next cycle.
                    if (new_duty_s == tgt_r) begin
                        done_r <= 1'b1;
                        if (stopping_r) begin
                            state_r    <= ST_IDLE;
                            stopping_r <= 1'b0;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end else begin
                        state_r <= ST_RAMP;
                    end
                end else begin
                    cnt_r <= cnt_r + 32'd1;
                end
            end else if ((state_r == ST_RAMP) || (state_r == ST_HOLD)) begin
                busy_r <= 1'b1;
            end else begin
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
            end
        end
    end

    assign ftw  = ftw_r;
    assign duty = duty_r;
    assign load = load_r;
    assign done = done_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_pwm_ramp.sv
// Self-checking bench for pwm_ramp: directed scenarios plus randomized start/stop
// commands checked against an event-list model of the ramp rules.
`timescale 1ns/1ps
module tb_pwm_ramp;
`ifdef PWM_RAMP_PERIOD_SYNC_EN
    localparam bit PSYNC = 1'b1;
`else
    localparam bit PSYNC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] duty;
        logic        done;
        logic        load;
        logic        busy;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] cfg_ftw = 32'd0;
    logic [31:0] cfg_target = 32'd0;
    logic [31:0] cfg_step = 32'd0;
    logic [31:0] cfg_interval = 32'd0;
    logic [31:0] ftw;
    logic [31:0] duty;
    logic        load;
    logic        busy;
    logic        done;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     t0 = 0;
    logic   busy_after = 1'b0;
    ev_t    ev_q[$];
    ev_t    exp_q[$];
    longint m_duty = 0;
    longint m_step = 0;
    longint m_int = 0;
    longint m_ftw = 0;
    bit     m_busy = 1'b0;

    pwm_ramp dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_ftw(cfg_ftw), .cfg_target(cfg_target), .cfg_step(cfg_step),
        .cfg_interval(cfg_interval), .ftw(ftw), .duty(duty), .load(load),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (load || done) ev_q.push_back(ev_t'{32'(cyc), duty, done, load, busy});

    // Expected load/done events of one command, as offsets from the command cycle.
    task automatic model_cmd(input bit is_start, input longint f, input longint tg,
                             input longint st, input longint iv);
        longint d, tgt, p;
        int k;
        exp_q.delete();
        if (is_start) begin
            m_ftw = f; m_step = st; m_int = iv;
            tgt = (tg > f) ? ((f + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : f + 1) : tg;
            exp_q.push_back(ev_t'{32'd1, 32'(m_duty), 1'b0, 1'b1, 1'b1});
        end else begin
            tgt = 0;
        end
        p = PSYNC ? m_ftw + 1 : 1;
        d = m_duty;
        k = 0;
        do begin
            k++;
            if (m_step == 0) d = tgt;
            else if (d < tgt) d = (d + m_step < tgt) ? d + m_step : tgt;
            else if (d > tgt) d = (d - tgt > m_step) ? d - m_step : tgt;
            exp_q.push_back(ev_t'{32'(1 + k * (m_int + 1) * p), 32'(d), d == tgt, 1'b1, 1'b1});
        end while (d != tgt);
        m_duty = d;
        m_busy = is_start;
    endtask

    task automatic issue(input bit s, input bit p, input logic [31:0] f, input logic [31:0] tg,
                         input logic [31:0] st, input logic [31:0] iv);
        @(negedge clk);
        cfg_ftw = f; cfg_target = tg; cfg_step = st; cfg_interval = iv;
        start = s; stop = p; t0 = cyc;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    // Issue a command, build its expected events and wait past the last one.
    task automatic run(input bit s, input bit p, input logic [31:0] f, input logic [31:0] tg,
                       input logic [31:0] st, input logic [31:0] iv);
        model_cmd(!p, longint'(f), longint'(tg), longint'(st), longint'(iv));
        issue(s, p, f, tg, st, iv);
        repeat (int'(exp_q[$].t)) @(negedge clk);
        busy_after = busy;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_duty = 0; m_busy = 1'b0;
        ev_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({ftw, duty, load, busy, done} !== 67'd0) begin
            errors++;
            $display("FAIL reset_hold: got ftw=%0d duty=%0d load=%0b busy=%0b done=%0b, want all 0", ftw, duty, load, busy, done);
        end
        do_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({ftw, duty, load, busy, done} !== 67'd0 || ev_q.size() != 0) begin
            errors++;
            $display("FAIL reset_release: got ftw=%0d duty=%0d busy=%0b events=%0d, want 0", ftw, duty, busy, ev_q.size());
        end
    endtask

    task automatic test_up_ramp;
        int n;
        ev_t got;
        do_reset;
        run(1'b1, 1'b0, 32'd99, 32'd50, 32'd10, 32'd3);
        n = 0;
        foreach (ev_q[i]) if (ev_q[i].t > 32'(t0)) begin
            got = ev_q[i]; got.t = got.t - 32'(t0);
            if (n < exp_q.size()) begin
                checks++;
                if (got !== exp_q[n]) begin
                    errors++;
                    $display("FAIL up_ramp ev%0d: got t=%0d duty=%0d done=%0b load=%0b busy=%0b, want t=%0d duty=%0d done=%0b", n, got.t, got.duty, got.done, got.load, got.busy, exp_q[n].t, exp_q[n].duty, exp_q[n].done);
                end
            end
            n++;
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL up_ramp count: got %0d loads, want 6", n); end
        checks++;
        if (ftw !== 32'd99 || busy !== 1'b1 || duty !== 32'd50) begin
            errors++;
            $display("FAIL up_ramp hold: got ftw=%0d busy=%0b duty=%0d, want 99 1 50", ftw, busy, duty);
        end
    endtask

    task automatic test_clamp;
        int n;
        ev_t got;
        do_reset;
        run(1'b1, 1'b0, 32'd99, 32'd45, 32'd20, 32'd0);
        n = 0;
        foreach (ev_q[i]) if (ev_q[i].t > 32'(t0)) begin
            got = ev_q[i]; got.t = got.t - 32'(t0);
            if (n < exp_q.size()) begin
                checks++;
                if (got !== exp_q[n]) begin
                    errors++;
                    $display("FAIL clamp ev%0d: got t=%0d duty=%0d done=%0b, want t=%0d duty=%0d done=%0b", n, got.t, got.duty, got.done, exp_q[n].t, exp_q[n].duty, exp_q[n].done);
                end
            end
            n++;
        end
        checks++;
        if (n != 4 || duty !== 32'd45) begin
            errors++;
            $display("FAIL clamp end: got %0d loads duty=%0d, want 4 loads duty=45", n, duty);
        end
    endtask

    task automatic test_above_period;
        int n;
        do_reset;
        run(1'b1, 1'b0, 32'd9, 32'd200, 32'd0, 32'd2);
        n = 0;
        foreach (ev_q[i]) if (ev_q[i].t > 32'(t0) && ev_q[i].done) n++;
        checks++;
        if (duty !== 32'd10 || ftw !== 32'd9 || n != 1) begin
            errors++;
            $display("FAIL above_period: got duty=%0d ftw=%0d dones=%0d, want 10 9 1", duty, ftw, n);
        end
    endtask

    // Ramp up to 50 and then leave HOLD with either stop or start+stop together.
    task automatic test_stop(input bit with_start);
        int n;
        ev_t got;
        do_reset;
        run(1'b1, 1'b0, 32'd99, 32'd50, 32'd20, 32'd1);
        run(with_start, 1'b1, 32'd7, 32'd3, 32'd1, 32'd0);
        n = 0;
        foreach (ev_q[i]) if (ev_q[i].t > 32'(t0)) begin
            got = ev_q[i]; got.t = got.t - 32'(t0);
            if (n < exp_q.size()) begin
                checks++;
                if (got !== exp_q[n]) begin
                    errors++;
                    $display("FAIL stop%0b ev%0d: got t=%0d duty=%0d done=%0b load=%0b busy=%0b, want t=%0d duty=%0d done=%0b", with_start, n, got.t, got.duty, got.done, got.load, got.busy, exp_q[n].t, exp_q[n].duty, exp_q[n].done);
                end
            end
            n++;
        end
        checks++;
        if (n != 3 || duty !== 32'd0 || ftw !== 32'd99) begin
            errors++;
            $display("FAIL stop%0b end: got %0d loads duty=%0d ftw=%0d, want 3 0 99", with_start, n, duty, ftw);
        end
        checks++;
        if (busy_after !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop%0b busy: got %0b/%0b after done, want 0", with_start, busy_after, busy);
        end
    endtask

    task automatic test_stop_idle;
        int n;
        issue(1'b0, 1'b1, 32'd5, 32'd5, 32'd1, 32'd0);
        repeat (6) @(negedge clk);
        n = 0;
        foreach (ev_q[i]) if (ev_q[i].t > 32'(t0)) n++;
        checks++;
        if (n != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: got %0d events busy=%0b, want 0 0", n, busy);
        end
    endtask

    task automatic test_restart;
        int n;
        ev_t got;
        do_reset;
        model_cmd(1'b1, 99, 100, 10, 3);
        issue(1'b1, 1'b0, 32'd99, 32'd100, 32'd10, 32'd3);
        repeat (5) @(negedge clk);
        m_duty = PSYNC ? 0 : 10;
        run(1'b1, 1'b0, 32'd60, 32'd30, 32'd5, 32'd0);
        n = 0;
        foreach (ev_q[i]) if (ev_q[i].t > 32'(t0)) begin
            got = ev_q[i]; got.t = got.t - 32'(t0);
            if (n < exp_q.size()) begin
                checks++;
                if (got !== exp_q[n]) begin
                    errors++;
                    $display("FAIL restart ev%0d: got t=%0d duty=%0d done=%0b, want t=%0d duty=%0d done=%0b", n, got.t, got.duty, got.done, exp_q[n].t, exp_q[n].duty, exp_q[n].done);
                end
            end
            n++;
        end
        checks++;
        if (n != exp_q.size() || ftw !== 32'd60 || duty !== 32'd30) begin
            errors++;
            $display("FAIL restart end: got %0d loads ftw=%0d duty=%0d, want %0d 60 30", n, ftw, duty, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        issue(1'b1, 1'b0, 32'd99, 32'd80, 32'd10, 32'd0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ftw, duty, load, busy, done} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid: got ftw=%0d duty=%0d load=%0b busy=%0b done=%0b, want all 0", ftw, duty, load, busy, done);
        end
        do_reset;
    endtask

    task automatic test_random;
        do_reset;
        for (int it = 0; it < 24; it++) begin
            logic [31:0] f, tg, st, iv;
            longint d0, tgt, stp;
            int n, want;
            bit is_stop;
            ev_t got;
            is_stop = m_busy && ($urandom_range(0, 2) == 0);
            f = $urandom_range(1, 40); tg = $urandom_range(0, 50);
            st = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 12);
            iv = $urandom_range(0, 3);
            d0 = m_duty;
            tgt = is_stop ? 0 : ((tg > f) ? longint'(f) + 1 : longint'(tg));
            stp = is_stop ? m_step : longint'(st);
            run(!is_stop, is_stop, f, tg, st, iv);
            n = 0;
            foreach (ev_q[i]) if (ev_q[i].t > 32'(t0)) begin
                got = ev_q[i]; got.t = got.t - 32'(t0);
                if (n < exp_q.size()) begin
                    checks++;
                    if (got !== exp_q[n]) begin
                        errors++;
                        $display("FAIL random%0d ev%0d: got t=%0d duty=%0d done=%0b load=%0b busy=%0b, want t=%0d duty=%0d done=%0b", it, n, got.t, got.duty, got.done, got.load, got.busy, exp_q[n].t, exp_q[n].duty, exp_q[n].done);
                    end
                end
                n++;
            end
            want = (stp == 0 || d0 == tgt) ? 1 :
                   int'(((d0 > tgt ? d0 - tgt : tgt - d0) + stp - 1) / stp);
            checks++;
            if (n - (is_stop ? 0 : 1) != want) begin
                errors++;
                $display("FAIL random%0d steps: got %0d, want %0d", it, n - (is_stop ? 0 : 1), want);
            end
            checks++;
            if (duty !== 32'(tgt) || busy !== m_busy) begin
                errors++;
                $display("FAIL random%0d end: got duty=%0d busy=%0b, want %0d %0b", it, duty, busy, tgt, m_busy);
            end
        end
    endtask

    initial begin
        test_reset;
        test_up_ramp;
        test_clamp;
        test_above_period;
        test_stop(1'b0);
        test_stop_idle;
        test_stop(1'b1);
        test_restart;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
